// File: rtl/load_align_pkg.sv
// ---------------------------------------------------------------------------
// load_align_pkg
// Shared types and helpers for the load alignment block.
//   load_op_t      : funct3 load encodings (LB, LH, LW, LBU, LHU)
//   state_t        : controller states (IDLE, RD0, RD1, DONE)
//   op_legal()     : true for the five supported load encodings
//   op_misaligned(): true when the access spills into the next word
//   load_data()    : shift the two-word window and extend to 32 bits
// ---------------------------------------------------------------------------
package load_align_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1,
        DONE
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    // A halfword only crosses the word boundary from byte 3; a word crosses
    // from any non-zero offset.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            LH, LHU: return off == 2'd3;
            LW:      return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    // dw = {second word, first word}; the addressed byte is moved to bit 0
    // and the result is truncated and extended according to the op.
    function automatic logic [31:0] load_data(input logic [63:0] dw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  op);
        logic [31:0] sh;
        sh = 32'(dw >> {off, 3'b000});
        case (op)
            LB:      return {{24{sh[7]}}, sh[7:0]};
            LH:      return {{16{sh[15]}}, sh[15:0]};
            LW:      return sh;
            LBU:     return {24'h0, sh[7:0]};
            LHU:     return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_if.sv
// ---------------------------------------------------------------------------
// load_align_if
// Bundles the core-side load handshake and the memory read channel.
//   ld_*  : load request from the core and the strobed result back
//   mem_* : word-aligned read requests to memory and the returned data
// Modports:
//   slave  : the load_align block view
//   master : the environment (core + memory) view
// ---------------------------------------------------------------------------
interface load_align_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_op;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        ld_fault;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  ld_valid, ld_addr, ld_op, mem_ready, mem_rdata,
        output ld_ready, ld_done, ld_data, ld_fault, mem_valid, mem_addr, mem_wstrb
    );

    modport master (
        output ld_valid, ld_addr, ld_op, mem_ready, mem_rdata,
        input  ld_ready, ld_done, ld_data, ld_fault, mem_valid, mem_addr, mem_wstrb
    );

endinterface

// File: rtl/load_align_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Combinational extraction of a load result from a two-word window.
//   rdata1 : second (higher-addressed) word, 0 for single-word loads
//   rdata0 : first word
//   off    : byte offset of the load within the first word
//   op     : funct3 load encoding
//   data   : aligned, sign/zero-extended result
// ---------------------------------------------------------------------------
module load_extract
    import load_align_pkg::*;
(
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata0,
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    assign data = load_data({rdata1, rdata0}, off, op);

endmodule

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Turns a byte-addressed load request into one or two word reads and
// returns the aligned, extended result with a one-cycle done strobe.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : load_align_if.slave (load handshake + memory read channel)
// Configuration:
//   MISALIGNED_LOAD_EN defined   : word-crossing loads read a second word
//   MISALIGNED_LOAD_EN undefined : word-crossing loads fault without access
// ---------------------------------------------------------------------------
module load_align
    import load_align_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    load_align_if.slave bus
);

    state_t      state;
    state_t      state_next;
    logic [31:0] mem_addr_q;
    logic [1:0]  off_q;
    logic [2:0]  op_q;
    logic [31:0] rdata0_q;
    logic [31:0] ld_data_q;
    logic        ld_fault_q;
    logic        req_fault;
    logic        need_rd1;
    logic [31:0] ext_lo;
    logic [31:0] ext_hi;
    logic [31:0] ext_data;

    // A faulting request skips memory entirely and goes straight to DONE.
`ifdef MISALIGNED_LOAD_EN
    assign req_fault = !op_legal(bus.ld_op);
    assign need_rd1  = op_misaligned(op_q, off_q);
`else
    assign req_fault = !op_legal(bus.ld_op) || op_misaligned(bus.ld_op, bus.ld_addr[1:0]);
    assign need_rd1  = 1'b0;
`endif

    // In RD1 the first word is already held and the live read is the second
    // word; in RD0 the live read is the only word and the upper half is 0.
    assign ext_lo = (state == RD1) ? rdata0_q      : bus.mem_rdata;
    assign ext_hi = (state == RD1) ? bus.mem_rdata : 32'h0;

    load_extract u_extract (
        .rdata1 (ext_hi),
        .rdata0 (ext_lo),
        .off    (off_q),
        .op     (op_q),
        .data   (ext_data)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mem_ready is only looked at while a read is open.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.ld_valid)  state_next = req_fault ? DONE : RD0;
            RD0:  if (bus.mem_ready) state_next = need_rd1 ? RD1 : DONE;
            RD1:  if (bus.mem_ready) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, read address sequencing and result registers. The
    // result registers only change on entry to DONE so they hold between
    // strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr_q <= 32'h0;
            off_q      <= 2'd0;
            op_q       <= 3'd0;
            rdata0_q   <= 32'h0;
            ld_data_q  <= 32'h0;
            ld_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_valid) begin
                        mem_addr_q <= {bus.ld_addr[31:2], 2'b00};
                        off_q      <= bus.ld_addr[1:0];
                        op_q       <= bus.ld_op;
                        if (req_fault) begin
                            ld_data_q  <= 32'h0;
                            ld_fault_q <= 1'b1;
                        end
                    end
                end
                RD0: begin
                    if (bus.mem_ready) begin
                        if (need_rd1) begin
                            rdata0_q   <= bus.mem_rdata;
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end else begin
                            ld_data_q  <= ext_data;
                            ld_fault_q <= 1'b0;
                        end
                    end
                end
                RD1: begin
                    if (bus.mem_ready) begin
                        ld_data_q  <= ext_data;
                        ld_fault_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready  = (state == IDLE);
    assign bus.mem_valid = (state == RD0) || (state == RD1);
    assign bus.ld_done   = (state == DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = 4'h0;
    assign bus.ld_data   = ld_data_q;
    assign bus.ld_fault  = ld_fault_q;

endmodule

// File: tb/tb_load_align.sv
// ---------------------------------------------------------------------------
// tb_load_align
// Self-checking bench for load_align: directed vector table, stray
// mem_ready, randomized loads against a byte-level reference model, and a
// mid-transaction reset. Honours MISALIGNED_LOAD_EN when defined.
// ---------------------------------------------------------------------------
module tb_load_align;
    import load_align_pkg::*;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    load_align_if bus();

    load_align u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory contents: preloaded words, otherwise an address hash.
    logic [31:0] mem [logic [31:0]];

    // Responder bookkeeping.
    logic        resp_en = 1'b1;
    logic        stray_req = 1'b0;
    logic        stray_ack = 1'b0;
    logic        pending = 1'b0;
    int          wait_left = 0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] reads [$];
    int          first_valid_cyc = -1;
    int          ready_cyc = -1;
    int          unstable_cnt = 0;
    int          badaddr_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // Byte-level reference: gather size bytes starting at the byte address
    // from the two covering words, then extend.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  output logic [31:0] data, output logic fault,
                                  output int nreads);
        int          size;
        bit          sgn;
        int          off;
        logic [31:0] word;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  b [8];
        logic [63:0] val;
        bit          crosses;
        case (op)
            3'd0:    begin size = 1; sgn = 1; end
            3'd1:    begin size = 2; sgn = 1; end
            3'd2:    begin size = 4; sgn = 0; end
            3'd4:    begin size = 1; sgn = 0; end
            3'd5:    begin size = 2; sgn = 0; end
            default: begin size = 0; sgn = 0; end
        endcase
        off  = int'(addr % 4);
        word = addr - 32'(off);
        data = 32'h0;
        fault = 1'b1;
        nreads = 0;
        if (size == 0) return;
        crosses = (off + size) > 4;
`ifndef MISALIGNED_LOAD_EN
        if (crosses) return;
`endif
        w0 = mem_word(word);
        w1 = crosses ? mem_word(word + 32'd4) : 32'h0;
        for (int i = 0; i < 4; i++) begin
            b[i]     = w0[8*i +: 8];
            b[4 + i] = w1[8*i +: 8];
        end
        val = 64'h0;
        for (int i = 0; i < size; i++) val |= 64'(b[off + i]) << (8 * i);
        if (sgn && val[8*size - 1]) val |= ~((64'd1 << (8 * size)) - 64'd1);
        data   = val[31:0];
        fault  = 1'b0;
        nreads = crosses ? 2 : 1;
    endfunction

    // Memory responder: random 0..3 cycle latency, records every read and
    // flags address changes while a read is outstanding.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            bus.mem_ready = 1'b0;
            if (!reset) begin
                pending = 1'b0;
            end else if (stray_req != stray_ack) begin
                stray_ack     = stray_req;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end else if (resp_en && bus.mem_valid) begin
                if (bus.mem_wstrb != 4'h0 || bus.mem_addr[1:0] != 2'b00) badaddr_cnt++;
                if (!pending) begin
                    pending   = 1'b1;
                    req_addr  = bus.mem_addr;
                    reads.push_back(bus.mem_addr);
                    wait_left = int'($urandom_range(0, 3));
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end else if (bus.mem_addr != req_addr) begin
                    unstable_cnt++;
                end
                if (wait_left == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_word(req_addr);
                    ready_cyc     = cyc;
                    pending       = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] addr,
                                  output logic [31:0] data, output logic fault,
                                  output int acc_cyc, output int done_cyc,
                                  output logic timeout, output logic done_after,
                                  output logic [31:0] data_after);
        int n;
        @(negedge clock);
        reads.delete();
        first_valid_cyc = -1;
        ready_cyc       = -1;
        unstable_cnt    = 0;
        badaddr_cnt     = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_op    = op;
        n = 0;
        while (!bus.ld_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        acc_cyc = cyc;
        @(negedge clock);
        bus.ld_valid = 1'b0;
        bus.ld_addr  = $urandom;
        bus.ld_op    = 3'($urandom);
        n = 0;
        while (!bus.ld_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        timeout  = !bus.ld_done;
        done_cyc = cyc;
        data     = bus.ld_data;
        fault    = bus.ld_fault;
        @(negedge clock);
        done_after = bus.ld_done;
        data_after = bus.ld_data;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] exp_data, input logic exp_fault);
        logic [31:0] data;
        logic        fault;
        int          acc_cyc;
        int          done_cyc;
        logic        timeout;
        logic        done_after;
        logic [31:0] data_after;
        logic [31:0] m_data;
        logic        m_fault;
        int          m_n;
        logic [31:0] word;
        apply_stimulus(op, addr, data, fault, acc_cyc, done_cyc, timeout, done_after, data_after);
        model(op, addr, m_data, m_fault, m_n);
        word = {addr[31:2], 2'b00};
        check_output({tag, "_timeout"}, 32'(timeout), 32'h0);
        check_output({tag, "_data"}, data, exp_data);
        check_output({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        check_output({tag, "_nreads"}, 32'(reads.size()), 32'(m_n));
        for (int i = 0; i < reads.size() && i < m_n; i++)
            check_output($sformatf("%s_rdaddr%0d", tag, i), reads[i], word + 32'(4 * i));
        if (exp_fault) begin
            check_output({tag, "_fault_latency"}, 32'(done_cyc), 32'(acc_cyc + 1));
        end else begin
            check_output({tag, "_first_valid"}, 32'(first_valid_cyc), 32'(acc_cyc + 1));
            check_output({tag, "_done_latency"}, 32'(done_cyc), 32'(ready_cyc + 1));
        end
        check_output({tag, "_done_one_cycle"}, 32'(done_after), 32'h0);
        check_output({tag, "_data_hold"}, data_after, data);
        check_output({tag, "_addr_stable"}, 32'(unstable_cnt), 32'h0);
        check_output({tag, "_addr_align"}, 32'(badaddr_cnt), 32'h0);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [2:0]  r_op;
        logic [31:0] m_data;
        logic        m_fault;
        int          m_n;
        int          n;
        logic        saw_done;

        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        bus.ld_op    = 3'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_output("rst_ld_ready", 32'(bus.ld_ready), 32'h1);
        check_output("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        check_output("rst_ld_done", 32'(bus.ld_done), 32'h0);
        check_output("rst_ld_fault", 32'(bus.ld_fault), 32'h0);
        check_output("rst_ld_data", bus.ld_data, 32'h0);
        check_output("rst_mem_addr", bus.mem_addr, 32'h0);
        check_output("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        vecs.push_back('{"lbu_103", 3'd4, 32'h103, 32'h80AA5511, 32'h0, 32'h00000080, 1'b0});
        vecs.push_back('{"lh_202", 3'd1, 32'h202, 32'h8001FFFF, 32'h0, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"lb_601", 3'd0, 32'h601, 32'h1234F0AB, 32'h0, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{"lhu_702", 3'd5, 32'h702, 32'hBEEF0000, 32'h0, 32'h0000BEEF, 1'b0});
        vecs.push_back('{"lw_800", 3'd2, 32'h800, 32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 1'b0});
        vecs.push_back('{"op7", 3'd7, 32'h500, 32'h11111111, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{"op3", 3'd3, 32'h504, 32'h22222222, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{"op6", 3'd6, 32'h508, 32'h33333333, 32'h0, 32'h0, 1'b1});
`ifdef MISALIGNED_LOAD_EN
        vecs.push_back('{"lw_301", 3'd2, 32'h301, 32'h44332211, 32'h88776655, 32'h55443322, 1'b0});
        vecs.push_back('{"lw_wrap", 3'd2, 32'hFFFFFFFE, 32'hDDCCBBAA, 32'h44332211, 32'h2211DDCC, 1'b0});
        vecs.push_back('{"lh_903", 3'd1, 32'h903, 32'h11223344, 32'h556677AA, 32'hFFFFAA11, 1'b0});
`else
        vecs.push_back('{"lw_301", 3'd2, 32'h301, 32'h44332211, 32'h88776655, 32'h0, 1'b1});
        vecs.push_back('{"lw_wrap", 3'd2, 32'hFFFFFFFE, 32'hDDCCBBAA, 32'h44332211, 32'h0, 1'b1});
        vecs.push_back('{"lh_903", 3'd1, 32'h903, 32'h11223344, 32'h556677AA, 32'h0, 1'b1});
`endif
        foreach (vecs[i]) begin
            mem[{vecs[i].addr[31:2], 2'b00}]          = vecs[i].w0;
            mem[{vecs[i].addr[31:2], 2'b00} + 32'd4]  = vecs[i].w1;
        end
        mem[32'h400] = 32'h0BADF00D;

        foreach (vecs[i])
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault);

        // A mem_ready pulse while idle must not start or complete anything.
        @(negedge clock);
        stray_req = ~stray_req;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.ld_done || !bus.ld_ready) saw_done = 1'b1;
        end
        check_output("stray_ready_ignored", 32'(saw_done), 32'h0);

        for (int i = 0; i < 60; i++) begin
            r_addr = $urandom;
            r_op   = 3'($urandom);
            model(r_op, r_addr, m_data, m_fault, m_n);
            run_and_check($sformatf("rnd%0d", i), r_op, r_addr, m_data, m_fault);
        end

        // Reset while a read is outstanding: outputs drop at once and the
        // abandoned load never reports.
        resp_en = 1'b0;
        @(negedge clock);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'hA00;
        bus.ld_op    = 3'd2;
        @(negedge clock);
        bus.ld_valid = 1'b0;
        n = 0;
        while (!bus.mem_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_output("rst_mid_mem_valid_before", 32'(bus.mem_valid), 32'h1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("rst_mid_mem_valid", 32'(bus.mem_valid), 32'h0);
        check_output("rst_mid_ld_ready", 32'(bus.ld_ready), 32'h1);
        check_output("rst_mid_ld_data", bus.ld_data, 32'h0);
        check_output("rst_mid_mem_addr", bus.mem_addr, 32'h0);
        saw_done = bus.ld_done;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.ld_done) saw_done = 1'b1;
        end
        check_output("rst_mid_no_done", 32'(saw_done), 32'h0);
        run_and_check("lw_400_after_rst", 3'd2, 32'h400, 32'h0BADF00D, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
